// File: rtl/sd_response_tx.sv
// SD card CMD-line response transmitter: frames R48/R136 responses with optional CRC7,
// paced by falling edges of an asynchronous sd_clock, with driver-enable and receiver-mask control.
module sd_response_tx #(
  parameter int unsigned WAIT_BEFORE = 2,
  parameter int unsigned WAIT_AFTER  = 2
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         sd_clock,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [119:0] data,
  output logic         sd_serial,
  output logic         write_enabled,
  output logic         read_disabled,
  output logic         busy,
  output logic         done
);

  localparam int unsigned DATA_W = 120;
  localparam int unsigned IDX_W  = 8;
  localparam int unsigned PRE_W  = 4;
  localparam int unsigned POST_W = 2;
  localparam int unsigned CRC_W  = 7;

  localparam logic [1:0] MODE_R48_NOCRC = 2'd1;
  localparam logic [1:0] MODE_R136      = 2'd2;
  localparam logic [1:0] MODE_RSVD      = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX_R48  = IDX_W'(47);
  localparam logic [IDX_W-1:0] LAST_IDX_R136 = IDX_W'(135);
  localparam logic [CRC_W-1:0] CRC_POLY      = 7'h09;

  typedef enum logic [1:0] {IDLE, PRE, SEND, POST} state_t;

  state_t              state_q, state_d;
  logic                s1, s2, s3;
  logic                fall_c;
  logic [1:0]          mode_q, mode_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
  logic [POST_W-1:0]   post_cnt_q, post_cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CRC_W-1:0]    crc_q, crc_d;
  logic                serial_d, we_d, rd_d, busy_d, done_d;
  logic                accept_c;
  logic                r136_c;
  logic [6:0]          data_idx_c;
  logic [2:0]          crc_idx_c;
  logic                cur_bit_c;
  logic                crc_cover_c;
  logic                crc_fb_c;
  logic [CRC_W-1:0]    crc_next_c;

  // sd_clock synchronizer; a fall needs s3 to have seen a 1 first
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sd_clock;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign fall_c   = s3 & ~s2;
  assign accept_c = start && (mode != MODE_RSVD);

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      mode_q        <= 2'd0;
      data_q        <= '0;
      pre_cnt_q     <= '0;
      post_cnt_q    <= '0;
      idx_q         <= '0;
      crc_q         <= '0;
      sd_serial     <= 1'b1;
      write_enabled <= 1'b0;
      read_disabled <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      data_q        <= data_d;
      pre_cnt_q     <= pre_cnt_d;
      post_cnt_q    <= post_cnt_d;
      idx_q         <= idx_d;
      crc_q         <= crc_d;
      sd_serial     <= serial_d;
      write_enabled <= we_d;
      read_disabled <= rd_d;
      busy          <= busy_d;
      done          <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept_c) state_d = PRE;
      PRE:  if (fall_c && (pre_cnt_q == PRE_W'(1))) state_d = SEND;
      SEND: if (fall_c && (idx_q == '0)) state_d = POST;
      POST: if (fall_c && (post_cnt_q == POST_W'(1))) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bit selection for the current frame index; CRC bits index the frozen CRC register MSB first
  always_comb begin
    r136_c     = (mode_q == MODE_R136);
    data_idx_c = 7'(idx_q - IDX_W'(8));
    crc_idx_c  = 3'(idx_q - IDX_W'(1));
    cur_bit_c  = 1'b1;
    if (idx_q == '0) begin
      cur_bit_c = 1'b1;
    end else if (idx_q < IDX_W'(8)) begin
      cur_bit_c = (mode_q == MODE_R48_NOCRC) ? 1'b1 : crc_q[crc_idx_c];
    end else if (r136_c) begin
      if (idx_q >= IDX_W'(134))      cur_bit_c = 1'b0;
      else if (idx_q >= IDX_W'(128)) cur_bit_c = 1'b1;
      else                           cur_bit_c = data_q[data_idx_c];
    end else begin
      if (idx_q >= IDX_W'(46)) cur_bit_c = 1'b0;
      else                     cur_bit_c = data_q[data_idx_c];
    end
    crc_cover_c = (idx_q >= IDX_W'(8)) && (!r136_c || (idx_q <= IDX_W'(127)));
    crc_fb_c    = cur_bit_c ^ crc_q[CRC_W-1];
    crc_next_c  = {crc_q[CRC_W-2:0], 1'b0} ^ (crc_fb_c ? CRC_POLY : CRC_W'(0));
  end

  // Output and datapath next values
  always_comb begin
    mode_d     = mode_q;
    data_d     = data_q;
    pre_cnt_d  = pre_cnt_q;
    post_cnt_d = post_cnt_q;
    idx_d      = idx_q;
    crc_d      = crc_q;
    serial_d   = sd_serial;
    we_d       = write_enabled;
    rd_d       = read_disabled;
    busy_d     = busy;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          mode_d    = mode;
          data_d    = data;
          busy_d    = 1'b1;
          rd_d      = 1'b1;
          serial_d  = 1'b1;
          pre_cnt_d = PRE_W'(WAIT_BEFORE);
          crc_d     = '0;
        end
      end
      PRE: begin
        if (fall_c) begin
          pre_cnt_d = pre_cnt_q - PRE_W'(1);
          if (pre_cnt_q == PRE_W'(1)) begin
            we_d  = 1'b1;
            idx_d = (mode_q == MODE_R136) ? LAST_IDX_R136 : LAST_IDX_R48;
          end
        end
      end
      SEND: begin
        if (fall_c) begin
          serial_d = cur_bit_c;
          if (crc_cover_c) crc_d = crc_next_c;
          if (idx_q == '0) post_cnt_d = POST_W'(WAIT_AFTER);
          else             idx_d      = idx_q - IDX_W'(1);
        end
      end
      POST: begin
        if (fall_c) begin
          we_d       = 1'b0;
          serial_d   = 1'b1;
          post_cnt_d = post_cnt_q - POST_W'(1);
          if (post_cnt_q == POST_W'(1)) begin
            rd_d   = 1'b0;
            busy_d = 1'b0;
            done_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sd_response_tx.sv
// Scoreboard bench for sd_response_tx: expected frame bits are queued at stimulus time
// and a clock-sampled monitor pops and compares them as the DUT shifts them out.
module tb_sd_response_tx;

  localparam int WB_A = 2;
  localparam int WA_A = 2;
  localparam int WB_B = 5;
  localparam int WA_B = 3;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         sd_a = 1'b1;
  logic         sd_b = 1'b1;
  logic         run_a = 1'b1;
  int           half_a = 3;
  int           half_b = 2;
  logic         start_a = 1'b0, start_b = 1'b0;
  logic [1:0]   mode_a = 2'd0, mode_b = 2'd0;
  logic [119:0] data_a = '0, data_b = '0;
  logic         ser_a, we_a, rd_a, busy_a, done_a;
  logic         ser_b, we_b, rd_b, busy_b, done_b;

  int checks = 0;
  int errors = 0;

  logic exp_q[$];
  int   len_q[$];

  always #5 clock = ~clock;

  initial forever begin
    repeat (half_a) @(negedge clock);
    if (run_a) sd_a = ~sd_a;
  end

  initial forever begin
    repeat (half_b) @(negedge clock);
    sd_b = ~sd_b;
  end

  sd_response_tx dut_a (
    .clock(clock), .reset_n(reset_n), .sd_clock(sd_a), .start(start_a),
    .mode(mode_a), .data(data_a), .sd_serial(ser_a), .write_enabled(we_a),
    .read_disabled(rd_a), .busy(busy_a), .done(done_a)
  );

  sd_response_tx #(.WAIT_BEFORE(WB_B), .WAIT_AFTER(WA_B)) dut_b (
    .clock(clock), .reset_n(reset_n), .sd_clock(sd_b), .start(start_b),
    .mode(mode_b), .data(data_b), .sd_serial(ser_b), .write_enabled(we_b),
    .read_disabled(rd_b), .busy(busy_b), .done(done_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic logic [6:0] crc7_model(input logic [119:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 119; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  // Monitor for dut_a: frame bits, timing of write_enabled and done
  initial begin : mon_a
    bit   prev_sd, prev_we, prev_busy, active, fell;
    logic e;
    int   n, len;
    prev_sd = 1'b1; prev_we = 1'b0; prev_busy = 1'b0; active = 1'b0; n = 0; len = 0;
    forever begin
      @(posedge clock); #2;
      fell    = prev_sd && !sd_a;
      prev_sd = sd_a;
      if (!reset_n) begin
        exp_q.delete();
        len_q.delete();
        active = 1'b0; prev_we = 1'b0; prev_busy = 1'b0;
        continue;
      end
      if (busy_a && !prev_busy) begin
        n = fell ? 1 : 0;
        if (len_q.size() == 0) flag("unexpected_busy_a");
        else begin
          len    = len_q.pop_front();
          active = 1'b1;
        end
      end else if (fell && active) begin
        n++;
      end
      if (active && we_a && !prev_we) check("we_rise_fall_a", 32'(n), 32'(WB_A));
      if (active && fell && n == WB_A + 1) check("preamble_a", 32'({we_a, ser_a}), 32'h3);
      if (active && fell && n >= WB_A + 2 && n <= WB_A + len + 1) begin
        if (exp_q.size() == 0) flag("exp_queue_empty_a");
        else begin
          e = exp_q.pop_front();
          check("frame_bit_a", 32'({we_a, ser_a}), 32'({1'b1, e}));
        end
      end
      if (done_a) begin
        if (!active) flag("spurious_done_a");
        else begin
          check("done_falls_a", 32'(n), 32'(WB_A + len + WA_A));
          check("done_outs_a", 32'({busy_a, rd_a, we_a, ser_a}), 32'b0001);
          check("bits_left_a", 32'(exp_q.size()), 32'd0);
          active = 1'b0;
        end
      end
      prev_we   = we_a;
      prev_busy = busy_a;
    end
  end

  // Monitor for dut_b: enable/mask timing with non-default waits
  initial begin : mon_b
    bit prev_sd, prev_we, prev_rd, prev_busy, active, fell;
    int n;
    prev_sd = 1'b1; prev_we = 1'b0; prev_rd = 1'b0; prev_busy = 1'b0; active = 1'b0; n = 0;
    forever begin
      @(posedge clock); #2;
      fell    = prev_sd && !sd_b;
      prev_sd = sd_b;
      if (busy_b && !prev_busy) begin
        n      = fell ? 1 : 0;
        active = 1'b1;
      end else if (fell && active) begin
        n++;
      end
      if (active && we_b && !prev_we) check("we_rise_fall_b", 32'(n), 32'(WB_B));
      if (active && prev_rd && !rd_b) check("rd_release_fall_b", 32'(n), 32'(WB_B + 48 + WA_B));
      if (done_b) begin
        if (!active) flag("spurious_done_b");
        else check("done_falls_b", 32'(n), 32'(WB_B + 48 + WA_B));
        active = 1'b0;
      end
      prev_we   = we_b;
      prev_rd   = rd_b;
      prev_busy = busy_b;
    end
  end

  task automatic send_a(input logic [1:0] m, input logic [119:0] d,
                        input logic [135:0] frame, input int len);
    for (int i = len - 1; i >= 0; i--) exp_q.push_back(frame[i]);
    len_q.push_back(len);
    @(negedge sd_a);
    mode_a  = m;
    data_a  = d;
    start_a = 1'b1;
    @(posedge clock); #1;
    start_a = 1'b0;
  endtask

  task automatic wait_idle_a(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (!busy_a) break;
      @(posedge clock); #1;
    end
    if (i == budget) flag("timeout_a");
    repeat (5) @(posedge clock);
    #1;
  endtask

  task automatic send_wait_b(input int budget);
    int i;
    @(negedge sd_b);
    mode_b  = 2'd0;
    data_b  = {82'd0, 6'd17, 32'hDEADBEEF};
    start_b = 1'b1;
    @(posedge clock); #1;
    start_b = 1'b0;
    for (i = 0; i < budget; i++) begin
      if (!busy_b) break;
      @(posedge clock); #1;
    end
    if (i == budget) flag("timeout_b");
    repeat (5) @(posedge clock);
    #1;
  endtask

  initial begin : stim
    logic [127:0] rnd;
    logic [119:0] payload;
    logic [135:0] f2;
    logic [3:0]   snap;
    logic [119:0] d0;

    d0 = {82'd0, 6'd55, 32'h00000120};

    repeat (5) @(posedge clock);
    #1;
    check("reset_outs_a", 32'({ser_a, we_a, rd_a, busy_a, done_a}), 32'b10000);
    check("reset_outs_b", 32'({ser_b, we_b, rd_b, busy_b, done_b}), 32'b10000);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (10) @(posedge clock);

    // R1 with CRC7
    send_a(2'd0, d0, {88'd0, 48'h37_00_00_01_20_83}, 48);
    wait_idle_a(2000);

    // R3 without CRC
    send_a(2'd1, {82'd0, 6'h3F, 32'h80FF8000}, {88'd0, 48'h3F_80_FF_80_00_FF}, 48);
    wait_idle_a(2000);

    // R2 with random payload, sd_clock stalled mid-frame
    rnd     = {$urandom, $urandom, $urandom, $urandom};
    payload = rnd[119:0];
    f2      = {2'b00, 6'h3F, payload, crc7_model(payload), 1'b1};
    send_a(2'd2, payload, f2, 136);
    repeat (200) @(posedge clock);
    run_a = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    snap = {ser_a, we_a, rd_a, busy_a};
    repeat (80) @(posedge clock);
    #1;
    check("stall_freeze_a", 32'({ser_a, we_a, rd_a, busy_a}), 32'(snap));
    run_a = 1'b1;
    wait_idle_a(4000);

    // Reserved mode is ignored
    @(negedge clock);
    mode_a  = 2'd3;
    start_a = 1'b1;
    @(posedge clock); #1;
    start_a = 1'b0;
    repeat (20) @(posedge clock);
    #1;
    check("mode3_ignored_a", 32'({busy_a, rd_a, we_a, ser_a}), 32'b0001);

    // Inputs disturbed after acceptance and a second start during SEND
    send_a(2'd0, d0, {88'd0, 48'h37_00_00_01_20_83}, 48);
    data_a = '1;
    mode_a = 2'd1;
    repeat (20) @(negedge sd_a);
    @(negedge clock);
    mode_a  = 2'd2;
    data_a  = {4{30'h2AAA5555}};
    start_a = 1'b1;
    @(posedge clock); #1;
    start_a = 1'b0;
    wait_idle_a(2000);

    // Reset abort around bit index 20
    send_a(2'd0, d0, {88'd0, 48'h37_00_00_01_20_83}, 48);
    repeat (29) @(negedge sd_a);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock); #1;
    check("abort_outs_a", 32'({ser_a, we_a, rd_a, busy_a, done_a}), 32'b10000);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(posedge clock);
    #1;
    check("abort_idle_a", 32'({busy_a, rd_a, we_a}), 32'b000);
    send_a(2'd1, {82'd0, 6'h3F, 32'h80FF8000}, {88'd0, 48'h3F_80_FF_80_00_FF}, 48);
    wait_idle_a(2000);

    // Non-default waits at 1:4 and 1:500 sd_clock ratios
    half_b = 2;
    repeat (10) @(posedge clock);
    send_wait_b(2000);
    half_b = 250;
    repeat (2) @(negedge sd_b);
    send_wait_b(40000);

    repeat (20) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
